// File: rtl/circuit_sweep_ctrl.sv
// circuit_sweep_ctrl: on-chip exhaustive sweep of a 3-input circuit.
// Drives vectors 0..7, captures a truth table, compares against EXPECTED.
module circuit_sweep_ctrl #(
    parameter int          SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth,
    output logic [7:0] mismatch
);

    // SETTLE of 0 behaves as 1; values above the counter range saturate
    localparam logic [3:0] SET_EFF =
        (SETTLE < 1)  ? 4'd1  :
        (SETTLE > 15) ? 4'd15 : 4'(SETTLE);
    localparam logic [3:0] CNT_LAST = SET_EFF - 4'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       go;
    logic       active;
    logic [7:0] truth_nxt;

    assign go = start & ~abort;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic; abort wins over progress while sweeping
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (go) state_nxt = DRIVE;
            DRIVE: begin
                if (abort)                 state_nxt = IDLE;
                else if (cnt == CNT_LAST)  state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)             state_nxt = IDLE;
                else if (idx == 3'd7)  state_nxt = DONE;
                else                   state_nxt = DRIVE;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // table with the current sample merged in, so the verdict is ready in DONE
    always_comb begin
        truth_nxt      = truth;
        truth_nxt[idx] = dut_out;
    end

    // sweep datapath: index, settle counter, captured table and verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= 3'd0;
            cnt      <= 4'd0;
            truth    <= 8'h00;
            pass     <= 1'b0;
            mismatch <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        idx      <= 3'd0;
                        cnt      <= 4'd0;
                        truth    <= 8'h00;
                        pass     <= 1'b0;
                        mismatch <= 8'h00;
                    end
                end
                DRIVE: begin
                    if (!abort) cnt <= cnt + 4'd1;
                end
                SAMPLE: begin
                    if (!abort) begin
                        truth <= truth_nxt;
                        cnt   <= 4'd0;
                        if (idx == 3'd7) begin
                            pass     <= (truth_nxt == EXPECTED);
                            mismatch <= truth_nxt ^ EXPECTED;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign active = (state == DRIVE) || (state == SAMPLE);

    // outputs decoded from registered state and index
    always_comb begin
        busy          = active;
        done          = (state == DONE);
        {in1,in2,in3} = active ? idx : 3'd0;
    end

endmodule
